// File: rtl/mode_counter_pkg.sv
// Shared encodings for the mode_counter block: terminal-behaviour modes and FSM states.
package mode_counter_pkg;

  // Terminal behaviour selected by the mode input; 2'b11 behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  // RUN counts normally; DONE freezes the count after a one-shot run completes.
  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Clock prescaler: issues a one-cycle step every prescale+1 unheld cycles.
module counter_prescaler #(
  parameter int PRE_SIZE = 4
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                hold,
  input  logic                restart,
  input  logic [PRE_SIZE-1:0] prescale,
  output logic                step
);

  localparam logic [PRE_SIZE-1:0] PRE_ONE = PRE_SIZE'(1);

  logic [PRE_SIZE-1:0] pre_cnt_q;
  logic [PRE_SIZE-1:0] pre_cnt_d;

  // Next prescaler count and step strobe; >= keeps a run-time drop of prescale from stalling.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    step      = 1'b0;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (!hold) begin
      if (pre_cnt_q >= prescale) begin
        step      = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
      end
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with prescaler, parallel load and wrap / saturate / one-shot terminal behaviour.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int PRE_SIZE = 4
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                hold,
  input  logic                clear,
  input  logic                load,
  input  logic [SIZE-1:0]     load_value,
  input  logic                up,
  input  logic [1:0]          mode,
  input  logic [SIZE-1:0]     limit,
  input  logic [PRE_SIZE-1:0] prescale,
  output logic [SIZE-1:0]     value,
  output logic                tc,
  output logic                done
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] value_q, value_d;
  logic            tc_q, tc_d;
  state_e          state_q, state_d;

  logic            step;
  logic [SIZE-1:0] term;
  logic            at_term;
  logic            is_sat;
  logic            is_oneshot;
  logic [SIZE-1:0] stepped_value;

  counter_prescaler #(
    .PRE_SIZE (PRE_SIZE)
  ) u_prescaler (
    .clk      (clk),
    .res_n    (res_n),
    .hold     (hold),
    .restart  (clear | load),
    .prescale (prescale),
    .step     (step)
  );

  // Terminal compare and the value a step would produce from the current count.
  always_comb begin
    term          = up ? limit : '0;
    at_term       = (value_q == term);
    is_sat        = (mode == MODE_SAT);
    is_oneshot    = (mode == MODE_ONESHOT);
    stepped_value = up ? (value_q + ONE) : (value_q - ONE);
    if (at_term && !is_sat && !is_oneshot) begin
      stepped_value = up ? '0 : limit;
    end
  end

  // Next value, tc and FSM state with clear > load > hold > step priority.
  always_comb begin
    value_d = value_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (clear) begin
      value_d = '0;
      state_d = RUN;
    end else if (load) begin
      value_d = load_value;
      state_d = RUN;
    end else if (!hold && step && (state_q == RUN)) begin
      // A saturated counter sitting at its terminal value neither moves nor re-fires tc.
      if (!(at_term && is_sat)) begin
        value_d = stepped_value;
        tc_d    = (stepped_value == term);
        if (is_oneshot && (stepped_value == term)) begin
          state_d = DONE;
        end
      end
    end
  end

  // Value, tc and state registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      value_q <= '0;
      tc_q    <= 1'b0;
      state_q <= RUN;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign value = value_q;
  assign tc    = tc_q;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mode_counter.sv
// Directed, table-driven bench for mode_counter with hand-written multi-cycle sequences.
module tb_mode_counter;

  logic       clk;
  logic       res_n;
  logic       hold;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       up;
  logic [1:0] mode;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic [7:0] value;
  logic       tc;
  logic       done;

  int errors = 0;
  int checks = 0;

  mode_counter #(
    .SIZE     (8),
    .PRE_SIZE (4)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .hold       (hold),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up         (up),
    .mode       (mode),
    .limit      (limit),
    .prescale   (prescale),
    .value      (value),
    .tc         (tc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic       hld;
    logic       dir_up;
    logic [1:0] md;
    logic [7:0] lim;
    logic [7:0] ldv;
    logic [3:0] pre;
    logic [7:0] ev;
    logic       etc;
    logic       edn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic h, logic u, logic [1:0] m,
                              logic [7:0] li, logic [7:0] lv, logic [3:0] p,
                              logic [7:0] ev, logic etc, logic edn);
    vec_t r;
    r.clr = c; r.ld = l; r.hld = h; r.dir_up = u; r.md = m;
    r.lim = li; r.ldv = lv; r.pre = p; r.ev = ev; r.etc = etc; r.edn = edn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] ev, input logic etc, input logic edn);
    chk({name, ".value"}, 32'(value), 32'(ev));
    chk({name, ".tc"}, 32'(tc), 32'(etc));
    chk({name, ".done"}, 32'(done), 32'(edn));
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    clear = 1'b0; load = 1'b0; hold = 1'b0;
  endtask

  initial begin
    int sat_vals[15];
    int pri_tail[3];
    res_n = 1'b0; hold = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    up = 1'b1; mode = 2'b00; limit = 8'd5; prescale = 4'd0;

    // ---------------- table construction ----------------
    // Wrap up, limit 5, prescale 0.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'((i + 1) % 6);
      vecs.push_back(mk(0, 0, 0, 1, 2'b00, 8'd5, 8'd0, 4'd0, e, (e == 8'd5), 0));
    end
    // Saturate down from 3 with prescale 2.
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 8'd5, 8'd3, 4'd2, 8'd3, 0, 0));
    sat_vals = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      vecs.push_back(mk(0, 0, 0, 0, 2'b01, 8'd5, 8'd3, 4'd2, 8'(sat_vals[i]), (i == 8), 0));
    end
    // Priority: clear > load > hold, and hold freezes the prescaler.
    vecs.push_back(mk(0, 1, 0, 1, 2'b00, 8'd200, 8'd7, 4'd2, 8'd7, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 2'b00, 8'd200, 8'd7, 4'd2, 8'd0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 2'b00, 8'd200, 8'd9, 4'd2, 8'd9, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 1, 1, 2'b00, 8'd200, 8'd9, 4'd2, 8'd9, 0, 0));
    pri_tail = '{9, 9, 10};
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 1, 2'b00, 8'd200, 8'd9, 4'd2, 8'(pri_tail[i]), 0, 0));
    // One-shot up to limit 4 from a clear.
    vecs.push_back(mk(1, 0, 0, 1, 2'b10, 8'd4, 8'd0, 4'd0, 8'd0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, 2'b10, 8'd4, 8'd0, 4'd0, 8'(i), (i == 4), (i == 4)));

    // ---------------- reset ----------------
    #12;
    chk_all("reset", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    res_n = 1'b1;
    #4;

    // ---------------- table replay ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; load = vecs[i].ld; hold = vecs[i].hld;
      up = vecs[i].dir_up; mode = vecs[i].md; limit = vecs[i].lim;
      load_value = vecs[i].ldv; prescale = vecs[i].pre;
      tick();
      $display("vec %0d: value=%0d tc=%0d done=%0d", i, value, tc, done);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].etc, vecs[i].edn);
    end

    // ---------------- one-shot frozen in DONE ----------------
    drive_idle();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) mode = 2'b00;   // mode change must not leave DONE
      tick();
      chk_all($sformatf("frozen%0d", i), 8'd4, 1'b0, 1'b1);
    end
    $display("done hold: value=%0d done=%0d", value, done);

    // Load of the terminal value itself must not raise tc.
    mode = 2'b10; load = 1'b1; load_value = 8'd4;
    tick();
    chk_all("load_term", 8'd4, 1'b0, 1'b0);
    // Load 1 and count 1,2,3,4 again.
    load_value = 8'd1;
    tick();
    chk_all("reload", 8'd1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_all($sformatf("rerun%0d", i), 8'(i), (i == 4), (i == 4));
    end
    $display("oneshot rerun: value=%0d tc=%0d done=%0d", value, tc, done);

    // ---------------- async reset while in DONE ----------------
    #3;
    res_n = 1'b0;
    #1;
    chk_all("rst_done", 8'd0, 1'b0, 1'b0);
    #1;
    res_n = 1'b1;
    $display("reset in DONE: value=%0d done=%0d", value, done);

    // ---------------- overshoot: 10 -> 255 -> 0 -> 5 ----------------
    mode = 2'b00; up = 1'b1; limit = 8'd5; prescale = 4'd0;
    load = 1'b1; load_value = 8'd10;
    tick();
    chk_all("ovs_load", 8'd10, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 1; i <= 251; i++) begin
      logic [7:0] e;
      e = 8'((10 + i) % 256);
      tick();
      chk_all($sformatf("ovs%0d", i), e, (e == 8'd5), 1'b0);
    end
    $display("overshoot end: value=%0d tc=%0d", value, tc);

    // ---------------- async reset mid-count / mid-prescale ----------------
    prescale = 4'd2;
    tick();
    chk_all("pre_mid", 8'd5, 1'b0, 1'b0);
    #3;
    res_n = 1'b0;
    #1;
    chk_all("rst_mid", 8'd0, 1'b0, 1'b0);
    #1;
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("post_rst%0d", i), (i == 2) ? 8'd1 : 8'd0, 1'b0, 1'b0);
    end
    $display("after reset release: value=%0d", value);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised successor to the basic hold/clear counter. It adds up/down direction, a programmable terminal value, a clock prescaler, parallel load, and three terminal behaviours: wrap, saturate and one-shot. It sits beside the existing counters in timer/event-count datapaths, and its single-cycle `tc` pulse drives downstream sequencers.

## Interface

Parameters:
- `SIZE`, default 8: counter width in bits.
- `PRE_SIZE`, default 4: prescaler width in bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `res_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  freezes both the prescaler and the counter.
- `clear`  in  1  synchronous clear.
- `load`  in  1  synchronous parallel load.
- `load_value`  in  SIZE  value written on `load`.
- `up`  in  1  direction: 1 = count up, 0 = count down.
- `mode`  in  2  terminal behaviour:
  - 00 wrap
  - 01 saturate
  - 10 one-shot
  - 11 treated as wrap
- `limit`  in  SIZE  terminal value when counting up; reload value when wrapping down.
- `prescale`  in  PRE_SIZE  one counter step every `prescale+1` unheld cycles.
- `value`  out  SIZE  registered count.
- `tc`  out  1  registered one-cycle pulse: a step just produced the terminal value.
- `done`  out  1  level: one-shot run has finished.

## Operation

- **Reset** (`res_n`=0, asynchronous): `value`=0, `tc`=0, `done`=0, prescaler count=0, state=RUN.
- **Per-cycle priority:** `clear` > `load` > `hold` > step.
  - `clear`: `value`=0, prescaler=0, state=RUN, `done`=0, `tc`=0.
  - `load`: `value`=`load_value`, prescaler=0, state=RUN, `done`=0, `tc`=0. A load never raises `tc`, even when `load_value` equals the terminal value.
  - `hold`: all state frozen; `tc`=0.
- **Prescaler:**
  - Counts unheld cycles.
  - A step is issued when `pre_cnt >= prescale`; `pre_cnt` then returns to 0. Otherwise `pre_cnt` increments.
  - The `>=` compare makes a run-time decrease of `prescale` safe.
  - In DONE the prescaler still runs, but its steps are suppressed.
- **Terminal value:** `limit` when `up`=1; 0 when `up`=0.
- **Step, in state RUN:**
  - Value at the terminal value, wrap mode: up goes to 0, down goes to `limit`.
  - Value at the terminal value, saturate mode: `value` holds.
  - Otherwise: up gives `value+1` mod 2^SIZE; down gives `value-1` mod 2^SIZE.
  - If `value` > `limit` while counting up, the count runs through 2^SIZE-1, wraps to 0, and continues to `limit`. Terminal detection is an equality compare only.
  - `tc`=1 in the cycle after any step whose new `value` equals the terminal value. A saturate hold does not re-fire `tc`.
- **State machine:** RUN, DONE.
  - RUN → DONE: in one-shot mode, on the step that makes `value` equal the terminal value. `done`=1 from that edge, and `tc` pulses once.
  - In DONE, steps are ignored and `value` is frozen.
  - DONE → RUN only on `clear` or `load`. A change of `mode` or `up` does not leave DONE.
- **Run-time changes:** `up`, `mode` and `limit` may change in any cycle. Each takes effect on the next step.

## Timing

- Latency from a step-qualifying edge to `value` updating: 1 cycle.
- `tc` is aligned with the terminal `value`: both become visible after the same edge.
- With `prescale`=N, `value` changes once every N+1 unheld cycles. The first step after `clear` or `load` comes N+1 cycles later.
- `hold` asserted for k cycles stretches the step spacing by exactly k cycles.
- `res_n` deassertion is synchronised externally. The first step can occur `prescale+1` cycles after reset release.
- Reset in mid-count or in DONE returns all outputs to their reset values immediately, asynchronously.

## Structure

- Package `mode_counter_pkg` holds:
  - the `mode` encodings (`MODE_WRAP`, `MODE_SAT`, `MODE_ONESHOT`);
  - the state typedef (RUN, DONE).
- Sub-module `counter_prescaler` (parameter `PRE_SIZE`):
  - inputs: `clk`, `res_n`, `hold`, `restart`, `prescale`;
  - output: `step`.
  - `restart` is driven by `clear | load`.
- Top level contains the value register, the terminal compare, the next-value mux, the state register and the `tc` register.

## Test plan

- **Wrap up:** SIZE=8, `limit`=5, `prescale`=0, wrap, up, 8 cycles → `value` 1,2,3,4,5,0,1,2; `tc`=1 only with `value`=5.
- **Saturate down with prescaler:** `load_value`=3, down, saturate, `prescale`=2 → `value` changes every 3 cycles: 3,2,1,0, then holds at 0; `tc` pulses once.
- **One-shot:** `limit`=4, up, one-shot from 0 → `done` rises with `value`=4, which stays frozen for 20 cycles. Then `load` of 1 → `done`=0 and counting resumes: 1,2,3,4.
- **Priority:** `clear`, `load` and `hold` asserted together with `value`=7 → `value`=0, `tc`=0. Then `load` with `hold` → `value`=`load_value`. `hold` alone for 3 cycles → `value` unchanged and prescaler frozen.
- **Overshoot:** `value`=10 via load, `limit`=5, up, wrap → counts 11…255, 0…5; `tc` fires only at 5.
- **Async reset:** `res_n` pulsed low in mid-count, in DONE, and mid-prescale → `value`=0, `tc`=0, `done`=0 before the next edge. The next step comes `prescale+1` cycles after release.
